// File: rtl/sub_serial.sv
// Bit-serial subtractor: out = a - b, one bit per clock LSB first, with final borrow (a < b).
// Optional macro SUB_SERIAL_SAT_EN clamps an underflowing result to zero.
module sub_serial #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out,
   output logic             borrow,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [CW-1:0]    count;
   logic             br;

   logic             d;
   logic             br_n;
   logic [WIDTH-1:0] shifted;

   // One full-subtractor cell working on the LSBs of the shifting operands
   assign d       = a_reg[0] ^ b_reg[0] ^ br;
   assign br_n    = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & br);
   assign shifted = {d, out[WIDTH-1:1]};

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_reg  <= '0;
         b_reg  <= '0;
         out    <= '0;
         count  <= '0;
         br     <= 1'b0;
         borrow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  a_reg  <= a;
                  b_reg  <= b;
                  out    <= '0;
                  count  <= '0;
                  br     <= 1'b0;
                  borrow <= 1'b0;
                  state  <= SUB;
               end
            end
            SUB: begin
               out   <= shifted;
               a_reg <= a_reg >> 1;
               b_reg <= b_reg >> 1;
               br    <= br_n;
               count <= count + 1'b1;
               if (count == LAST) begin
                  borrow <= br_n;
                  state  <= DONE;
`ifdef SUB_SERIAL_SAT_EN
                  if (br_n) begin
                     out <= '0;
                  end
`endif
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               // The unused encoding recovers to IDLE without touching data
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial (WIDTH=8): directed vector table plus multi-cycle sequences.
// Expected results follow SUB_SERIAL_SAT_EN when the macro is defined for the build.
module tb_sub_serial;

   logic       clk;
   logic       rst;
   logic       en;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] out;
   logic       borrow;
   logic       busy;
   logic       done;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp_out;
      logic [7:0] exp_out_sat;
      logic       exp_borrow;
   } vec_t;

   vec_t vecs[10];

   sub_serial #(.WIDTH(8)) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .a(a),
      .b(b),
      .out(out),
      .borrow(borrow),
      .busy(busy),
      .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Pulse en for one start edge, then wait (bounded) for done.
   // lat counts edges from the start edge up to the one that raises done.
   task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb,
                                output int lat, output int busy_cycles);
      a = va;
      b = vb;
      en = 1'b1;
      lat = -1;
      busy_cycles = 0;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         en = 1'b0;
         if (busy) busy_cycles++;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   function automatic logic [7:0] pickOut(input logic [7:0] wrap_v, input logic [7:0] sat_v);
`ifdef SUB_SERIAL_SAT_EN
      return sat_v;
`else
      return wrap_v;
`endif
   endfunction

   initial begin
      int lat;
      int bc;
      int seen;
      int first_done;
      int second_done;
      int done_count;
      logic [7:0] exp_o;

      vecs[0] = '{8'd200, 8'd55,  8'd145, 8'd145, 1'b0};
      vecs[1] = '{8'd5,   8'd9,   8'd252, 8'd0,   1'b1};
      vecs[2] = '{8'd255, 8'd255, 8'd0,   8'd0,   1'b0};
      vecs[3] = '{8'd0,   8'd0,   8'd0,   8'd0,   1'b0};
      vecs[4] = '{8'd100, 8'd1,   8'd99,  8'd99,  1'b0};
      vecs[5] = '{8'd0,   8'd1,   8'd255, 8'd0,   1'b1};
      vecs[6] = '{8'd128, 8'd127, 8'd1,   8'd1,   1'b0};
      vecs[7] = '{8'd1,   8'd255, 8'd2,   8'd0,   1'b1};
      vecs[8] = '{8'd170, 8'd85,  8'd85,  8'd85,  1'b0};
      vecs[9] = '{8'd7,   8'd3,   8'd4,   8'd4,   1'b0};

      rst = 1'b1;
      en  = 1'b0;
      a   = '0;
      b   = '0;
      #2;
      checkOutput("reset_out", out, 0);
      checkOutput("reset_borrow", borrow, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("idle_busy", busy, 0);

      for (int i = 0; i < 10; i++) begin
         exp_o = pickOut(vecs[i].exp_out, vecs[i].exp_out_sat);
         applyStimulus(vecs[i].a, vecs[i].b, lat, bc);
         checkOutput($sformatf("latency[%0d]", i), lat, 9);
         checkOutput($sformatf("busy_cycles[%0d]", i), bc, 9);
         checkOutput($sformatf("out[%0d]", i), out, exp_o);
         checkOutput($sformatf("borrow[%0d]", i), borrow, vecs[i].exp_borrow);
         @(posedge clk);
         #1;
         checkOutput($sformatf("done_one_cycle[%0d]", i), done, 0);
         checkOutput($sformatf("back_to_idle[%0d]", i), busy, 0);
         repeat (2) @(posedge clk);
         #1;
         checkOutput($sformatf("out_held[%0d]", i), out, exp_o);
         checkOutput($sformatf("borrow_held[%0d]", i), borrow, vecs[i].exp_borrow);
      end

      // Operands and en toggled during SUB/DONE must not disturb the captured operation
      a = 8'd200;
      b = 8'd55;
      en = 1'b1;
      lat = -1;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         a = 8'($urandom);
         b = 8'($urandom);
         en = 1'b1;
         if (done) begin
            lat = k;
            break;
         end
      end
      checkOutput("scramble_latency", lat, 9);
      checkOutput("scramble_out", out, 145);
      checkOutput("scramble_borrow", borrow, 0);
      @(posedge clk);
      #1;
      en = 1'b0;
      checkOutput("scramble_no_restart", busy, 0);
      checkOutput("scramble_out_kept", out, 145);
      @(posedge clk);
      #1;

      // Continuous en: back-to-back operations, done pulses 10 cycles apart
      a = 8'd100;
      b = 8'd1;
      en = 1'b1;
      first_done = -1;
      second_done = -1;
      done_count = 0;
      for (int k = 1; k <= 25; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            done_count++;
            checkOutput($sformatf("b2b_out[%0d]", done_count), out, 99);
            if (first_done < 0) first_done = k;
            else if (second_done < 0) second_done = k;
         end
      end
      en = 1'b0;
      checkOutput("b2b_done_count", done_count, 2);
      checkOutput("b2b_first_done", first_done, 9);
      checkOutput("b2b_spacing", second_done - first_done, 10);
      seen = 0;
      for (int k = 0; k < 20 && busy; k++) begin
         @(posedge clk);
         #1;
         seen = k;
      end
      checkOutput("b2b_drain_idle", busy, 0);

      // Reset during the 4th SUB cycle discards the operation
      a = 8'd200;
      b = 8'd55;
      en = 1'b1;
      @(posedge clk);
      #1;
      en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("pre_rst_busy", busy, 1);
      rst = 1'b1;
      #1;
      checkOutput("rst_out", out, 0);
      checkOutput("rst_borrow", borrow, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (done || busy) seen++;
      end
      checkOutput("no_done_after_rst", seen, 0);
      applyStimulus(8'd7, 8'd3, lat, bc);
      checkOutput("post_rst_latency", lat, 9);
      checkOutput("post_rst_out", out, 4);
      checkOutput("post_rst_borrow", borrow, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
